// File: rtl/riscv_mem_pkg.sv
// Shared widths, store-buffer entry type and the youngest-match search used
// by the data-memory store buffer.
package riscv_mem_pkg;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned MEM_WORDS = 1 << ADDR_W;
  localparam int unsigned PTR_W     = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  typedef struct packed {
    logic             hit;
    logic [PTR_W-1:0] idx;
  } sb_match_t;

  // Walk from tail-1 (youngest) back towards the oldest slot; the first valid match wins.
  function automatic sb_match_t sb_match_youngest(
    input sb_entry_t [SB_DEPTH-1:0] ents,
    input logic [PTR_W-1:0]         tail,
    input logic [ADDR_W-1:0]        addr
  );
    sb_match_t        res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int unsigned k = 1; k <= SB_DEPTH; k++) begin
      idx = tail - PTR_W'(k);
      if (!res.hit && ents[idx].vld && (ents[idx].addr == addr)) begin
        res.hit = 1'b1;
        res.idx = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_dmem_sbuf_if.sv
// Core MEM-stage to data-memory request/response bundle.
interface riscv_dmem_sbuf_if;
  import riscv_mem_pkg::*;

  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] data_mem_addr;
  logic [DATA_W-1:0] data_mem_wdata;
  logic [DATA_W-1:0] data_mem_rdata;

  modport master (
    output mem_write, mem_read, data_mem_addr, data_mem_wdata,
    input  data_mem_rdata
  );

  modport slave (
    input  mem_write, mem_read, data_mem_addr, data_mem_wdata,
    output data_mem_rdata
  );
endinterface

// File: rtl/riscv_store_buffer.sv
// In-order store FIFO with a youngest-match forwarding lookup port.
module riscv_store_buffer
  import riscv_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data
);

  sb_entry_t [SB_DEPTH-1:0] ents;
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  sb_match_t                match;

  assign full      = (count == CNT_W'(SB_DEPTH));
  assign empty     = (count == '0);
  assign head_addr = ents[head].addr;
  assign head_data = ents[head].data;

  always_comb begin
    match   = sb_match_youngest(ents, tail, lk_addr);
    lk_hit  = match.hit;
    lk_data = ents[match.idx].data;
  end

  // When full, push and pop hit the same slot; the push is written last so it wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ents  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        ents[head].vld <= 1'b0;
        head           <= head + PTR_W'(1);
      end
      if (push) begin
        ents[tail] <= '{vld: 1'b1, addr: push_addr, data: push_data};
        tail       <= tail + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_dmem_sbuf.sv
// Data-memory subsystem: store buffer draining into a word array in idle
// cycles, with same-cycle load data forwarded from the youngest buffered store.
module riscv_dmem_sbuf
  import riscv_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  riscv_dmem_sbuf_if.slave         bus,
  output logic [CNT_W-1:0]         sb_count,
  output logic                     sb_empty,
  output logic                     sb_full,
  output logic                     protocol_err
);

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic              drain;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              lk_hit;
  logic [DATA_W-1:0] lk_data;
  logic              illegal;

  assign illegal = bus.mem_read && bus.mem_write;

  // Drain in idle cycles, or make room when a store arrives at a full buffer.
  assign drain = (!bus.mem_read && !bus.mem_write && !sb_empty)
              || (bus.mem_write && sb_full);

  riscv_store_buffer u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.mem_write),
    .push_addr (bus.data_mem_addr),
    .push_data (bus.data_mem_wdata),
    .pop       (drain),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (sb_count),
    .full      (sb_full),
    .empty     (sb_empty),
    .lk_addr   (bus.data_mem_addr),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data)
  );

  // Array contents survive reset; only the write port is clocked.
  always_ff @(posedge clk) begin
    if (drain) begin
      mem[head_addr] <= head_data;
    end
  end

  always_comb begin
    bus.data_mem_rdata = '0;
    if (bus.mem_read && !bus.mem_write) begin
      bus.data_mem_rdata = lk_hit ? lk_data : mem[bus.data_mem_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
    end else if (illegal) begin
      protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_dmem_sbuf.sv
// Directed bench for riscv_dmem_sbuf against a queue/array reference model.
module tb_riscv_dmem_sbuf;
  import riscv_mem_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  logic [CNT_W-1:0] sb_count;
  logic sb_empty;
  logic sb_full;
  logic protocol_err;

  riscv_dmem_sbuf_if bus ();

  riscv_dmem_sbuf dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sb_count     (sb_count),
    .sb_empty     (sb_empty),
    .sb_full      (sb_full),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: FIFO of pending stores plus an array with per-word "known" flags.
  ent_t              q[$];
  logic [DATA_W-1:0] mem_m [MEM_WORDS];
  bit                known [MEM_WORDS];
  bit                perr_m;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] obs_rdata;
  logic [CNT_W-1:0]  obs_count;
  logic              obs_empty;
  logic              obs_full;
  logic              obs_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_pop();
    ent_t e;
    e = q.pop_front();
    mem_m[e.a] = e.d;
    known[e.a] = 1'b1;
  endtask

  // One core cycle: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic step(input bit w, input bit r, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] exp_rd;
    bit                rd_known;
    bit                hit;
    bus.mem_write      = w;
    bus.mem_read       = r;
    bus.data_mem_addr  = a;
    bus.data_mem_wdata = d;
    @(negedge clk);
    exp_rd   = '0;
    rd_known = 1'b1;
    if (r && !w) begin
      hit = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!hit && q[i].a == a) begin
          hit    = 1'b1;
          exp_rd = q[i].d;
        end
      end
      if (!hit) begin
        rd_known = known[a];
        exp_rd   = mem_m[a];
      end
    end
    obs_rdata = bus.data_mem_rdata;
    obs_count = sb_count;
    obs_empty = sb_empty;
    obs_full  = sb_full;
    obs_perr  = protocol_err;
    if (rd_known) chk("rdata", obs_rdata, exp_rd);
    chk("sb_count", 32'(obs_count), 32'(q.size()));
    chk("sb_empty", 32'(obs_empty), 32'(q.size() == 0));
    chk("sb_full", 32'(obs_full), 32'(q.size() == SB_DEPTH));
    chk("protocol_err", 32'(obs_perr), 32'(perr_m));
    @(posedge clk);
    if (w) begin
      if (q.size() == SB_DEPTH) model_pop();
      q.push_back('{a: a, d: d});
    end else if (!r && q.size() > 0) begin
      model_pop();
    end
    if (r && w) perr_m = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) known[i] = 1'b0;
    perr_m             = 1'b0;
    rst_n              = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_read       = 1'b0;
    bus.data_mem_addr  = '0;
    bus.data_mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(sb_count), 32'd0);
    chk("reset_empty", 32'(sb_empty), 32'd1);
    chk("reset_full", 32'(sb_full), 32'd0);
    chk("reset_perr", 32'(protocol_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: store, drain, load from array
    step(1, 0, 8'h10, 32'hDEADBEEF);
    idle(1);
    step(0, 1, 8'h10, '0);
    chk("t1_rdata", obs_rdata, 32'hDEADBEEF);
    chk("t1_empty", 32'(obs_empty), 32'd1);

    // T2: forward on the very next cycle
    step(1, 0, 8'h20, 32'h11);
    step(0, 1, 8'h20, '0);
    chk("t2_rdata", obs_rdata, 32'h11);
    chk("t2_count", 32'(obs_count), 32'd1);
    idle(1);

    // T3: same-address stores, youngest wins in forwarding and in the array
    step(1, 0, 8'h30, 32'hA);
    step(1, 0, 8'h30, 32'hB);
    step(0, 1, 8'h30, '0);
    chk("t3_fwd", obs_rdata, 32'hB);
    idle(2);
    step(0, 1, 8'h30, '0);
    chk("t3_array", obs_rdata, 32'hB);
    chk("t3_empty", 32'(obs_empty), 32'd1);

    // T4: overflow forces a same-cycle drain of the oldest entry
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 32'(i + 1));
    chk("t4_full", 32'(obs_full), 32'd1);
    chk("t4_count", 32'(obs_count), 32'd4);
    step(0, 1, 8'h40, '0);
    chk("t4_arr40", obs_rdata, 32'h1);
    for (int i = 1; i < 5; i++) begin
      step(0, 1, 8'(8'h40 + i), '0);
      chk("t4_fwd", obs_rdata, 32'(i + 1));
    end
    idle(4);

    // T5: reset mid-drain discards buffered stores, array keeps old data
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h60 + i), 32'(32'hAA00 + i));
    idle(3);
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h60 + i), 32'(32'h1100 + i));
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("t5_count", 32'(sb_count), 32'd0);
    chk("t5_perr", 32'(protocol_err), 32'd0);
    q.delete();
    perr_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 1, 8'h60, '0);
    chk("t5_drained", obs_rdata, 32'h1100);
    step(0, 1, 8'h61, '0);
    chk("t5_old61", obs_rdata, 32'hAA01);
    step(0, 1, 8'h62, '0);
    chk("t5_old62", obs_rdata, 32'hAA02);

    // T6: illegal read+write sets sticky error, store still lands
    step(1, 1, 8'h50, 32'h7);
    chk("t6_rdata", obs_rdata, 32'h0);
    step(0, 1, 8'h50, '0);
    chk("t6_fwd", obs_rdata, 32'h7);
    chk("t6_perr", 32'(obs_perr), 32'd1);
    idle(3);
    step(0, 0, 8'h50, '0);
    chk("t6_sticky", 32'(obs_perr), 32'd1);
    chk("t6_rd_idle", obs_rdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
